timer_intr_ctrl: RTL

- Machine-timer and interrupt-request block sitting directly upstream of the CSR array.
- Holds the 64-bit free-running counter `mtime` and the `mtimecmp` comparator.
- Synchronizes and latches the external interrupt line.
- Produces the level requests `g_interrupt` and `frc_cntr_val_leq`, plus the one-shot `interrupts_in_pc_state` that the CSR array uses to capture `mepc`/`mcause` and clear MIE.

---
 rtl/timer_intr_ctrl_pkg.sv | 31 +++
 rtl/irq_sync_edge.sv | 34 +++
 rtl/timer_intr_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/timer_intr_ctrl_pkg.sv
// Shared definitions for the machine-timer / interrupt-request block.
// Contents: register word addresses, INTCTRL bit positions, privilege
// encodings, the mtimecmp reset constant and the interrupt-take FSM states.
package timer_intr_ctrl_pkg;

    // Register word addresses (reg_adr); 5-7 are reserved.
    localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
    localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] ADR_INTCTRL     = 3'd4;

    // INTCTRL bit positions.
    localparam int unsigned INTCTRL_EXT_PEND = 0;  // read, write-1-to-clear
    localparam int unsigned INTCTRL_TMR_EN   = 1;  // read/write
    localparam int unsigned INTCTRL_SYNC_EXT = 2;  // read-only

    // Privilege encodings.
    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    // mtimecmp comes out of reset as far away as possible so no request fires.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        StIdle,
        StIssued
    } take_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   async_in    - asynchronous input line
//   sync_out    - synchronized level
//   rise_pulse  - one-cycle pulse on a synchronized 0->1 transition
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out   = sync_q;
    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/timer_intr_ctrl.sv
// Machine timer (64-bit mtime / mtimecmp) and interrupt-request generation
// feeding the CSR array.
// Optional feature macro: TIMER_PRESCALE_EN - when defined, mtime advances once
// every PRESCALE enabled clocks; otherwise once per enabled clock.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   reg_we/reg_re/reg_adr         - register write/read strobes, word address
//   reg_wdata / reg_rdata         - write data / registered read data
//   ext_irq                       - asynchronous external interrupt line
//   csr_rmie/csr_meie/csr_mtie    - mstatus.MIE, mie.MEIE, mie.MTIE
//   cpu_stat_pc                   - CPU is in a state where a trap can be taken
//   g_interrupt                   - external interrupt request (level)
//   frc_cntr_val_leq              - timer interrupt request (level)
//   interrupts_in_pc_state        - one-cycle interrupt-take pulse
//   g_interrupt_priv              - request privilege (always M-mode)
module timer_intr_ctrl
    import timer_intr_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic        reg_re,
    input  logic [2:0]  reg_adr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic        ext_irq,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        cpu_stat_pc,
    output logic        g_interrupt,
    output logic        frc_cntr_val_leq,
    output logic        interrupts_in_pc_state,
    output logic [1:0]  g_interrupt_priv
);

`ifdef TIMER_PRESCALE_EN
    localparam bit PrescaleEn = 1'b1;
`else
    localparam bit PrescaleEn = 1'b0;
`endif
    // Divider collapses to 1 (tick every enabled clock) when prescaling is off.
    localparam int unsigned Div   = (PrescaleEn && PRESCALE > 1) ? PRESCALE : 1;
    localparam int unsigned PresW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(Div - 1);

    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [31:0]      hi_shadow_q, hi_shadow_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ext_pend_q, ext_pend_d;
    logic             tmr_en_q, tmr_en_d;
    logic [PresW-1:0] presc_q, presc_d;
    take_state_e      state_q, state_d;

    logic        sync_ext;
    logic        ext_rise;
    logic        tick;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_intctrl;
    logic        any_req;
    logic        take;
    logic [31:0] intctrl_rd;

    irq_sync_edge u_ext_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (ext_irq),
        .sync_out   (sync_ext),
        .rise_pulse (ext_rise)
    );

    assign wr_mtime_lo = reg_we & (reg_adr == ADR_MTIME_LO);
    assign wr_mtime_hi = reg_we & (reg_adr == ADR_MTIME_HI);
    assign wr_cmp_lo   = reg_we & (reg_adr == ADR_MTIMECMP_LO);
    assign wr_cmp_hi   = reg_we & (reg_adr == ADR_MTIMECMP_HI);
    assign wr_intctrl  = reg_we & (reg_adr == ADR_INTCTRL);

    assign tick = tmr_en_q & (presc_q == PresMax);

    always_comb begin
        presc_d = presc_q;
        if (wr_mtime_lo | wr_mtime_hi) begin
            presc_d = '0;
        end else if (tmr_en_q) begin
            presc_d = (presc_q == PresMax) ? '0 : presc_q + 1'b1;
        end
    end

    // A write to either half wins over the increment; the other half holds.
    always_comb begin
        mtime_d = mtime_q + {63'd0, tick};
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], reg_wdata};
        end else if (wr_mtime_hi) begin
            mtime_d = {reg_wdata, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) mtimecmp_d[31:0]  = reg_wdata;
        if (wr_cmp_hi) mtimecmp_d[63:32] = reg_wdata;
    end

    always_comb begin
        tmr_en_d = wr_intctrl ? reg_wdata[INTCTRL_TMR_EN] : tmr_en_q;
        // A new edge beats a same-cycle clear so no interrupt is lost.
        ext_pend_d = ext_rise |
                     (ext_pend_q & ~(wr_intctrl & reg_wdata[INTCTRL_EXT_PEND]));
    end

    always_comb begin
        intctrl_rd                   = '0;
        intctrl_rd[INTCTRL_EXT_PEND] = ext_pend_q;
        intctrl_rd[INTCTRL_TMR_EN]   = tmr_en_q;
        intctrl_rd[INTCTRL_SYNC_EXT] = sync_ext;
    end

    // Reading MTIME_LO freezes the upper half so a LO-then-HI pair is coherent.
    always_comb begin
        rdata_d     = rdata_q;
        hi_shadow_d = hi_shadow_q;
        if (reg_re) begin
            case (reg_adr)
                ADR_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                ADR_MTIME_HI:    rdata_d = hi_shadow_q;
                ADR_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                ADR_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                ADR_INTCTRL:     rdata_d = intctrl_rd;
                default:         rdata_d = '0;
            endcase
        end
    end

    assign g_interrupt      = ext_pend_q & csr_meie;
    assign frc_cntr_val_leq = tmr_en_q & csr_mtie & (mtime_q >= mtimecmp_q);
    assign any_req          = g_interrupt | frc_cntr_val_leq;

    // One pulse per take; re-arming needs MIE to drop first.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_stat_pc & csr_rmie & any_req) begin
                    take    = 1'b1;
                    state_d = StIssued;
                end
            end
            StIssued: begin
                if (!csr_rmie) state_d = StIdle;
            end
        endcase
    end

    assign interrupts_in_pc_state = take;
    assign g_interrupt_priv       = M_MODE;
    assign reg_rdata              = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RST;
            hi_shadow_q <= '0;
            rdata_q     <= '0;
            ext_pend_q  <= 1'b0;
            tmr_en_q    <= 1'b0;
            presc_q     <= '0;
            state_q     <= StIdle;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            rdata_q     <= rdata_d;
            ext_pend_q  <= ext_pend_d;
            tmr_en_q    <= tmr_en_d;
            presc_q     <= presc_d;
            state_q     <= state_d;
        end
    end

endmodule
